pulse_gate: RTL and testbench

Trigger-synchronous sample gate that sits directly upstream of the pulse integrator. It takes the continuous ADC sample stream and forwards exactly n_samples valid samples per radar pulse, starting cfg_delay samples after each trigger rising edge. Its output stream is valid only inside pulses, which gives the integrator clean per-pulse sample framing. It also provides a pulse counter and sticky error flags for the PS.

---
 rtl/pulse_gate.sv | 143 ++++++++++++++
 tb/tb_pulse_gate.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gate.sv
// Trigger-synchronous sample gate: forwards n_samples valid ADC samples per
// radar pulse, starting cfg_delay valid samples after each trigger rising edge.
module pulse_gate #(
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       trig_in,
  input  logic                       enable,
  input  logic [15:0]                cfg_delay,
  input  logic [15:0]                n_samples,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [31:0]                pulse_count,
  output logic                       trig_miss,
  output logic                       overflow,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE} state_t;

  state_t      state;
  logic        trig_d;
  logic        enable_d;
  logic [15:0] delay_lat;
  logic [15:0] n_lat;
  logic [15:0] delay_cnt;
  logic [15:0] samp_cnt;

  logic        trig_edge;
  logic        start;
  state_t      phase;
  logic [15:0] cur_delay;
  logic [15:0] cur_n;
  logic [15:0] cur_dcnt;
  logic [15:0] cur_scnt;
  logic        delay_done;
  logic        fwd;
  logic        last;

  assign s_axis_tready = 1'b1;
  assign busy          = (state != IDLE);

  // The trigger-edge cycle is processed as the first cycle of the pulse, so its
  // sample already counts toward the delay (or is captured when the delay is 0).
  always_comb begin
    trig_edge  = trig_in & ~trig_d;
    start      = (state == IDLE) & trig_edge & enable & (n_samples != 16'd0);
    phase      = state;
    cur_delay  = delay_lat;
    cur_n      = n_lat;
    cur_dcnt   = delay_cnt;
    cur_scnt   = samp_cnt;
    if (start) begin
      phase     = (cfg_delay == 16'd0) ? CAPTURE : DELAY;
      cur_delay = cfg_delay;
      cur_n     = n_samples;
      cur_dcnt  = 16'd0;
      cur_scnt  = 16'd0;
    end
    delay_done = (phase == DELAY) & s_axis_tvalid & (cur_dcnt == cur_delay - 16'd1);
    fwd        = (phase == CAPTURE) & s_axis_tvalid;
    last       = fwd & (cur_scnt == cur_n - 16'd1);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      trig_d        <= 1'b0;
      enable_d      <= 1'b0;
      delay_lat     <= 16'd0;
      n_lat         <= 16'd0;
      delay_cnt     <= 16'd0;
      samp_cnt      <= 16'd0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      pulse_count   <= 32'd0;
      trig_miss     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      trig_d   <= trig_in;
      enable_d <= enable;

      if (start) begin
        delay_lat <= cfg_delay;
        n_lat     <= n_samples;
      end

      case (phase)
        DELAY: begin
          samp_cnt <= cur_scnt;
          if (delay_done) begin
            state     <= CAPTURE;
            delay_cnt <= 16'd0;
          end else begin
            state     <= DELAY;
            delay_cnt <= s_axis_tvalid ? cur_dcnt + 16'd1 : cur_dcnt;
          end
        end
        CAPTURE: begin
          delay_cnt <= cur_dcnt;
          state     <= last ? IDLE : CAPTURE;
          samp_cnt  <= fwd ? cur_scnt + 16'd1 : cur_scnt;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // No output buffering: a beat not taken by the integrator is simply lost.
      m_axis_tvalid <= fwd;
      m_axis_tlast  <= last;
      if (fwd) begin
        m_axis_tdata <= s_axis_tdata;
      end

      if (enable & ~enable_d) begin
        pulse_count <= 32'd0;
      end else if (last) begin
        pulse_count <= pulse_count + 32'd1;
      end

      if (trig_edge & (state != IDLE)) begin
        trig_miss <= 1'b1;
      end else if (!enable & (state == IDLE)) begin
        trig_miss <= 1'b0;
      end

      if (m_axis_tvalid & ~m_axis_tready) begin
        overflow <= 1'b1;
      end else if (!enable & (state == IDLE)) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_gate.sv
// Directed bench for pulse_gate: stimulus pushes expected beats into a queue,
// an independent negedge monitor pops and compares every m_axis beat.
module tb_pulse_gate;
  localparam int W = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          trig_in;
  logic          enable;
  logic [15:0]   cfg_delay;
  logic [15:0]   n_samples;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [31:0]   pulse_count;
  logic          trig_miss;
  logic          overflow;
  logic          busy;

  int            compared   = 0;
  int            mismatched = 0;
  logic [W-1:0]  sample_val;
  logic [W:0]    exp_q[$];
  logic [W:0]    mon_e;

  always #5 aclk = ~aclk;

  pulse_gate #(.AXIS_DATA_WIDTH(W)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .trig_in       (trig_in),
    .enable        (enable),
    .cfg_delay     (cfg_delay),
    .n_samples     (n_samples),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pulse_count   (pulse_count),
    .trig_miss     (trig_miss),
    .overflow      (overflow),
    .busy          (busy)
  );

  // Monitor: every presented beat must match the head of the expected queue.
  always @(negedge aclk) begin
    if (m_axis_tvalid) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL out_beat: got data %0d last %0b, expected no beat", m_axis_tdata, m_axis_tlast);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_axis_tlast, m_axis_tdata} !== mon_e) begin
          mismatched++;
          $display("FAIL out_beat: got data %0d last %0b, expected data %0d last %0b",
                   m_axis_tdata, m_axis_tlast, mon_e[W-1:0], mon_e[W]);
        end else begin
          $display("beat data=%0d last=%0b", m_axis_tdata, m_axis_tlast);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s = %0d", name, act);
    end
  endtask

  task automatic expect_seq(input logic [31:0] first, input int len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1), first + 32'(i)});
    end
  endtask

  task automatic drain_check(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // One cycle per iteration; cycle c carries sample c when the stream is continuous.
  task automatic run(input int n, input int t1, input int t2, input bit gap,
                     input int bp_at, input int dis_at, input int rst_at);
    for (int c = 0; c < n; c++) begin
      s_axis_tvalid = gap ? (c % 2 == 0) : 1'b1;
      s_axis_tdata  = sample_val;
      trig_in       = (c == t1) || (c == t2);
      m_axis_tready = !(bp_at >= 0 && c >= bp_at && c < bp_at + 2);
      if (dis_at >= 0 && c >= dis_at) enable = 1'b0;
      aresetn       = !(c == rst_at);
      @(posedge aclk); #1;
      if (s_axis_tvalid) sample_val++;
    end
    trig_in       = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    aresetn       = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; trig_in = 1'b0;
    enable = 1'b0; cfg_delay = 16'd0; n_samples = 16'd0; m_axis_tready = 1'b1;
    sample_val = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulse_count", pulse_count, 32'd0);
    check("rst_flags", {30'd0, trig_miss, overflow}, 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);

    aresetn = 1'b1; enable = 1'b1;

    // Basic pulse: edge at sample 10, delay 3 -> 13..17
    cfg_delay = 16'd3; n_samples = 16'd5; sample_val = '0;
    expect_seq(32'd13, 5);
    run(25, 10, -1, 1'b0, -1, -1, -1);
    drain_check("basic_leftover");
    check("basic_pulse_count", pulse_count, 32'd1);
    check("basic_trig_miss", 32'(trig_miss), 32'd0);

    // Gapped: edge at valid sample 5 -> 8..12
    sample_val = '0;
    expect_seq(32'd8, 5);
    run(30, 10, -1, 1'b1, -1, -1, -1);
    drain_check("gapped_leftover");
    check("gapped_pulse_count", pulse_count, 32'd2);

    // Zero delay: edge-cycle sample is the first forwarded
    cfg_delay = 16'd0; n_samples = 16'd4; sample_val = '0;
    expect_seq(32'd10, 4);
    run(20, 10, -1, 1'b0, -1, -1, -1);
    drain_check("zero_delay_leftover");
    check("zero_delay_pulse_count", pulse_count, 32'd3);

    // Zero length: edge ignored
    n_samples = 16'd0; sample_val = '0;
    run(20, 5, -1, 1'b0, -1, -1, -1);
    drain_check("zero_len_leftover");
    check("zero_len_pulse_count", pulse_count, 32'd3);
    check("zero_len_busy", 32'(busy), 32'd0);

    // Early retrigger two samples into capture
    cfg_delay = 16'd3; n_samples = 16'd5; sample_val = '0;
    expect_seq(32'd13, 5);
    run(25, 10, 15, 1'b0, -1, -1, -1);
    drain_check("retrig_leftover");
    check("retrig_pulse_count", pulse_count, 32'd4);
    check("retrig_trig_miss", 32'(trig_miss), 32'd1);

    // Disable in idle clears flags; re-enable clears pulse_count
    run(2, -1, -1, 1'b0, -1, 0, -1);
    check("idle_disable_trig_miss", 32'(trig_miss), 32'd0);
    enable = 1'b1;
    run(2, -1, -1, 1'b0, -1, -1, -1);
    check("reenable_pulse_count", pulse_count, 32'd0);

    // Back-pressure: beats still presented, overflow raised
    sample_val = '0;
    expect_seq(32'd13, 5);
    run(25, 10, -1, 1'b0, 15, -1, -1);
    drain_check("bp_leftover");
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_pulse_count", pulse_count, 32'd1);

    // Disable mid-pulse: pulse completes, then flags clear
    sample_val = '0;
    expect_seq(32'd13, 5);
    run(25, 10, -1, 1'b0, -1, 14, -1);
    drain_check("disable_leftover");
    check("disable_overflow", 32'(overflow), 32'd0);
    check("disable_busy", 32'(busy), 32'd0);
    check("disable_pulse_count", pulse_count, 32'd2);
    enable = 1'b1;
    run(2, -1, -1, 1'b0, -1, -1, -1);
    check("reenable2_pulse_count", pulse_count, 32'd0);

    // Full pulse 5..9, then reset in the middle of the second pulse
    sample_val = '0;
    expect_seq(32'd5, 5);
    exp_q.push_back({1'b0, 32'd13});
    exp_q.push_back({1'b0, 32'd14});
    run(22, 2, 10, 1'b0, -1, -1, 15);
    drain_check("reset_leftover");
    check("reset_pulse_count", pulse_count, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
